// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, bit shifting and ACK check.
// Optional second attempt on failure when PS2_TX_RETRY_EN is defined.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send_command,
  input  logic [7:0] command_to_send,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_nack,
  output logic       error_timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int STA_W = $clog2(START_TIMEOUT + 1);
  localparam int XFR_W = $clog2(XFER_TIMEOUT + 1);

  // The REQ cycle is the last of the INHIBIT_CYCLES cycles with the clock held low.
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
  localparam logic [STA_W-1:0] STA_LAST = STA_W'(START_TIMEOUT - 1);
  localparam logic [STA_W-1:0] STA_MAX  = STA_W'(START_TIMEOUT);
  localparam logic [XFR_W-1:0] XFR_LAST = XFR_W'(XFER_TIMEOUT - 1);
  localparam logic [XFR_W-1:0] XFR_MAX  = XFR_W'(XFER_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, WAIT_FIRST, SHIFT, WAIT_ACK, WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [STA_W-1:0] sta_cnt_q, sta_cnt_d;
  logic [XFR_W-1:0] xfr_cnt_q, xfr_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic             dat_drv_q, dat_drv_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             tmo_q, tmo_d;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             dat_meta_q, dat_sync_q;
  logic             fall;
  logic             fail_tmo, fail_nack;
`ifdef PS2_TX_RETRY_EN
  logic             attempt_q, attempt_d;
  logic [7:0]       cmd_q, cmd_d;
`endif

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  assign fall = clk_prev_q & ~clk_sync_q;

  assign command_was_sent = done_q;
  assign error_nack       = nack_q;
  assign error_timeout    = tmo_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      sta_cnt_q  <= '0;
      xfr_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dat_drv_q  <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      tmo_q      <= 1'b0;
      // Synchronizers start at the released (high) level so reset never fakes a falling edge.
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      attempt_q  <= 1'b0;
      cmd_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      sta_cnt_q  <= sta_cnt_d;
      xfr_cnt_q  <= xfr_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      dat_drv_q  <= dat_drv_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      tmo_q      <= tmo_d;
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
`ifdef PS2_TX_RETRY_EN
      attempt_q  <= attempt_d;
      cmd_q      <= cmd_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    sta_cnt_d  = sta_cnt_q;
    xfr_cnt_d  = xfr_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    dat_drv_d  = dat_drv_q;
    ack_d      = ack_q;
    done_d     = 1'b0;
    nack_d     = 1'b0;
    tmo_d      = 1'b0;
    fail_tmo   = 1'b0;
    fail_nack  = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    busy       = 1'b1;
`ifdef PS2_TX_RETRY_EN
    attempt_d  = attempt_q;
    cmd_d      = cmd_q;
`endif
    // Transfer timer keeps running from the first fall until the line-idle check resolves.
    if ((state_q == SHIFT || state_q == WAIT_ACK || state_q == WAIT_IDLE) && xfr_cnt_q != XFR_MAX)
      xfr_cnt_d = xfr_cnt_q + XFR_W'(1);

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (send_command) begin
          state_d   = INHIBIT;
          inh_cnt_d = '0;
          shift_d   = frame(command_to_send);
          ack_d     = 1'b0;
`ifdef PS2_TX_RETRY_EN
          attempt_d = 1'b0;
          cmd_d     = command_to_send;
`endif
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        sta_cnt_d  = '0;
        xfr_cnt_d  = '0;
        bit_cnt_d  = '0;
        dat_drv_d  = 1'b0;
        if (inh_cnt_q >= INH_LAST) state_d = REQ;
        else if (inh_cnt_q != INH_MAX) inh_cnt_d = inh_cnt_q + INH_W'(1);
      end
      REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        state_d    = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        ps2_dat_oe = 1'b1;
        if (fall) begin
          state_d   = SHIFT;
          dat_drv_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = 4'd1;
          xfr_cnt_d = '0;
        end else if (sta_cnt_q == STA_LAST) begin
          fail_tmo = 1'b1;
        end else if (sta_cnt_q != STA_MAX) begin
          sta_cnt_d = sta_cnt_q + STA_W'(1);
        end
      end
      SHIFT: begin
        ps2_dat_oe = dat_drv_q;
        if (fall) begin
          dat_drv_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          if (bit_cnt_q != 4'd15) bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = WAIT_ACK;
        end else if (xfr_cnt_q == XFR_LAST) begin
          fail_tmo = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (fall) begin
          ack_d   = ~dat_sync_q;
          state_d = WAIT_IDLE;
        end else if (xfr_cnt_q == XFR_LAST) begin
          fail_tmo = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          if (ack_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            fail_nack = 1'b1;
          end
        end else if (xfr_cnt_q == XFR_LAST) begin
          fail_tmo = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail_tmo || fail_nack) begin
`ifdef PS2_TX_RETRY_EN
      if (!attempt_q) begin
        attempt_d = 1'b1;
        state_d   = INHIBIT;
        inh_cnt_d = '0;
        shift_d   = frame(cmd_q);
        ack_d     = 1'b0;
      end else begin
        state_d = IDLE;
        tmo_d   = fail_tmo;
        nack_d  = fail_nack;
      end
`else
      state_d = IDLE;
      tmo_d   = fail_tmo;
      nack_d  = fail_nack;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Self-checking bench for ps2_command_tx with a behavioural keyboard model on the open-drain lines.
module tb_ps2_command_tx;

  localparam int INH = 10;
  localparam int STO = 200;
  localparam int XTO = 2000;
`ifdef PS2_TX_RETRY_EN
  localparam int FAIL_ATTEMPTS = 2;
`else
  localparam int FAIL_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_command = 1'b0;
  logic [7:0] command_to_send = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_pin, ps2_dat_pin;
  logic       ps2_clk_oe, ps2_dat_oe, busy;
  logic       command_was_sent, error_nack, error_timeout;

  int tests = 0;
  int fails = 0;
  logic [9:0] last_frame = '0;

  always #5 clk = ~clk;

  assign ps2_clk_pin = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_pin = dev_dat & ~ps2_dat_oe;

  ps2_command_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (rst),
    .send_command    (send_command),
    .command_to_send (command_to_send),
    .ps2_clk_i       (ps2_clk_pin),
    .ps2_dat_i       (ps2_dat_pin),
    .ps2_clk_oe      (ps2_clk_oe),
    .ps2_dat_oe      (ps2_dat_oe),
    .busy            (busy),
    .command_was_sent(command_was_sent),
    .error_nack      (error_nack),
    .error_timeout   (error_timeout)
  );

  // Line monitor: running totals, read as differences around each step.
  int   mon_clkoe = 0, mon_inh = 0, mon_done = 0, mon_nack = 0, mon_tmo = 0, mon_bad = 0;
  logic prev_busy = 1'b0, prev_clkoe = 1'b0;
  always @(negedge clk) begin
    if (ps2_clk_oe) mon_clkoe <= mon_clkoe + 1;
    if (ps2_clk_oe && !prev_clkoe) mon_inh <= mon_inh + 1;
    if (command_was_sent) mon_done <= mon_done + 1;
    if (error_nack) mon_nack <= mon_nack + 1;
    if (error_timeout) mon_tmo <= mon_tmo + 1;
    if ((command_was_sent || error_nack || error_timeout) && (busy || !prev_busy))
      mon_bad <= mon_bad + 1;
    prev_busy  <= busy;
    prev_clkoe <= ps2_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame from the protocol rules: data LSB first, odd parity, stop 1.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    send_command    = 1'b1;
    command_to_send = b;
    @(negedge clk);
    send_command    = 1'b0;
  endtask

  // Keyboard side: waits for request-to-send, then clocks nclk bits (40-cycle period),
  // sampling data on rising edges. With nclk < 11 it returns with the clock held low.
  task automatic kbd_xfer(input int nclk, input bit ack, input int dly,
                          output logic [9:0] got, output bit ok);
    int n;
    got = '0;
    ok  = 1'b1;
    n   = 0;
    while (!(ps2_clk_pin && !ps2_dat_pin) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      ok = 1'b0;
      return;
    end
    repeat (dly) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      if (i == 10) begin
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      if (nclk < 11 && i == nclk - 1) return;
      dev_clk = 1'b1;
      if (i < 10) got[i] = ps2_dat_pin;
      if (i == 10) dev_dat = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_txn(input string tag, input logic [7:0] b, input int attempts,
                        input bit ack_last, input int dly);
    int s_clkoe, s_inh, s_done, s_nack, s_tmo, s_bad;
    logic [9:0] got;
    bit ok;
    s_clkoe = mon_clkoe; s_inh = mon_inh; s_done = mon_done;
    s_nack = mon_nack; s_tmo = mon_tmo; s_bad = mon_bad;
    strobe(b);
    for (int a = 0; a < attempts; a++) begin
      kbd_xfer(11, (a == attempts - 1) ? ack_last : 1'b0, dly, got, ok);
      chk({tag, "_req"}, {31'd0, ok}, 32'd1);
      chk({tag, "_frame"}, {22'd0, got}, {22'd0, ref_frame(b)});
    end
    last_frame = got;
    wait_idle(tag);
    chk({tag, "_clkoe_cycles"}, mon_clkoe - s_clkoe, INH * attempts);
    chk({tag, "_inhibits"}, mon_inh - s_inh, attempts);
    chk({tag, "_done"}, mon_done - s_done, {31'd0, ack_last});
    chk({tag, "_nack"}, mon_nack - s_nack, {31'd0, !ack_last});
    chk({tag, "_tmo"}, mon_tmo - s_tmo, 0);
    chk({tag, "_pulse_vs_busy"}, mon_bad - s_bad, 0);
  endtask

  initial begin
    int s_done, s_nack, s_tmo, s_inh, s_clkoe, run, n;
    logic [9:0] got;
    bit ok;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    chk("rst_in_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("rst_in_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_pulses", {29'd0, command_was_sent, error_nack, error_timeout}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("rst_out_busy", {31'd0, busy}, 32'd0);

    do_txn("ed", 8'hED, 1, 1'b1, 5);
    chk("ed_bits", {22'd0, last_frame}, {22'd0, 10'b11_1110_1101});
    do_txn("x01", 8'h01, 1, 1'b1, 12);
    chk("x01_parity", {31'd0, last_frame[8]}, 32'd0);
    do_txn("x00", 8'h00, 1, 1'b1, 30);
    chk("x00_parity", {31'd0, last_frame[8]}, 32'd1);

    // Keyboard never clocks: measure the last run of WAIT_FIRST cycles before the pulse.
    s_tmo = mon_tmo; s_inh = mon_inh; s_done = mon_done; s_nack = mon_nack;
    strobe(8'hF4);
    run = 0;
    n   = 0;
    while (!error_timeout && n < 3000) begin
      @(negedge clk);
      n++;
      if (!error_timeout) begin
        if (busy && !ps2_clk_oe && ps2_dat_oe) run++;
        else run = 0;
      end
    end
    chk("tmo_seen", {31'd0, error_timeout}, 32'd1);
    chk("tmo_wait_cycles", run, STO);
    chk("tmo_oe_after", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("tmo_busy_after", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("tmo_count", mon_tmo - s_tmo, 1);
    chk("tmo_inhibits", mon_inh - s_inh, FAIL_ATTEMPTS);
    chk("tmo_no_other", (mon_done - s_done) + (mon_nack - s_nack), 0);

    do_txn("nack", 8'hED, FAIL_ATTEMPTS, 1'b0, 10);

    // Re-strobes with 0x55 during INHIBIT and mid-shift must be ignored.
    s_done = mon_done; s_inh = mon_inh;
    strobe(8'hFF);
    repeat (3) @(negedge clk);
    strobe(8'h55);
    fork
      kbd_xfer(11, 1'b1, 20, got, ok);
      begin
        repeat (150) @(negedge clk);
        strobe(8'h55);
      end
    join
    chk("restrobe_req", {31'd0, ok}, 32'd1);
    chk("restrobe_frame", {22'd0, got}, {22'd0, ref_frame(8'hFF)});
    wait_idle("restrobe");
    chk("restrobe_done", mon_done - s_done, 1);
    chk("restrobe_inhibits", mon_inh - s_inh, 1);

    // Reset while bit 4 of 0xED (a 0) is on the line.
    s_done = mon_done; s_nack = mon_nack; s_tmo = mon_tmo;
    strobe(8'hED);
    kbd_xfer(5, 1'b1, 8, got, ok);
    chk("midrst_req", {31'd0, ok}, 32'd1);
    chk("midrst_bit4_drive", {31'd0, ps2_dat_oe}, 32'd1);
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_pulse", (mon_done - s_done) + (mon_nack - s_nack) + (mon_tmo - s_tmo), 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    do_txn("post_rst", 8'hA5, 1, 1'b1, 3);
`ifdef PS2_TX_RETRY_EN
    do_txn("retry", 8'h3C, 2, 1'b1, 7);
`endif

    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      repeat ($urandom_range(1, 30)) @(negedge clk);
      do_txn($sformatf("rnd%0d_%02h", k, rb), rb, 1, 1'b1, int'($urandom_range(2, 80)));
    end

    s_clkoe = mon_clkoe;
    repeat (5) @(negedge clk);
    chk("final_quiet", mon_clkoe - s_clkoe, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_command_tx.md
Name: ps2_command_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the keyboard link that complements the existing PS/2 receive path.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard:
  - drives PS2_CLK/PS2_DAT through open-drain enables;
  - checks the device ACK;
  - reports done or error to game logic.
- Sits beside PS2_Controller. The top level ties the enables to the inout pins (pin driven low when enable=1, otherwise Z).

Parameters:
- INHIBIT_CYCLES, 5000, cycles of CLOCK_50 that the clock line is held low before the request (100 us at 50 MHz).
- START_TIMEOUT, 750000, cycles to wait for the device's first falling clock edge (15 ms).
- XFER_TIMEOUT, 100000, cycles allowed from first falling edge to the line-idle check (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- send_command  in  1  one-cycle request strobe; sampled only in IDLE.
- command_to_send  in  8  byte to send; latched on the accepted strobe.
- ps2_clk_i  in  1  raw PS2_CLK pin level.
- ps2_dat_i  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high in every state except IDLE.
- command_was_sent  out  1  one-cycle pulse on ACK received.
- error_nack  out  1  one-cycle pulse when the ACK bit is sampled high.
- error_timeout  out  1  one-cycle pulse on start or transfer timeout.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0 (both lines released); counters and shift register cleared.
  - Reset mid-transfer releases both lines immediately and emits no pulse.
- Input conditioning:
  - ps2_clk_i and ps2_dat_i each pass through a 2-flop synchronizer.
  - fall = synced clk was 1 last cycle and is 0 now.
- On accept, latch a 10-bit shift register {stop=1, parity=~^byte, byte[7:0]}. Bits go out LSB first.
- IDLE: oe's=0. send_command=1 -> INHIBIT, counter cleared. The strobe is ignored in all other states.
- INHIBIT: clk_oe=1. After exactly INHIBIT_CYCLES cycles -> REQ.
- REQ (1 cycle): clk_oe=1, dat_oe=1 (start bit 0) -> WAIT_FIRST.
- WAIT_FIRST: clk_oe=0, dat_oe=1.
  - fall -> SHIFT, presenting bit0 (dat_oe=~shift[0]) and shifting right. Transfer counter starts.
  - START_TIMEOUT cycles without fall -> error_timeout pulse, IDLE.
- SHIFT: on each fall, present the next bit. After the stop bit (10th fall, dat_oe=0) -> WAIT_ACK.
- WAIT_ACK: dat_oe=0. On the next fall, sample synced data; 0 = ACK -> WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and dat=1, then:
  - ACK: command_was_sent pulse;
  - otherwise: error_nack pulse;
  - then IDLE.
- Transfer timer: runs from the first fall through WAIT_IDLE. Reaching XFER_TIMEOUT -> error_timeout pulse, release lines, IDLE.
- Simultaneous fall and timeout terminal count in the same cycle: the fall wins and the timer does not fire that cycle.
- Exactly one result pulse per accepted request. The pulse and busy dropping occur in the same cycle.
- Counters are sized to ceil(log2(param+1)) bits and saturate (no wrap).

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - on NACK or either timeout of the first attempt, silently restart from INHIBIT with the same latched byte;
  - busy stays high;
  - the error pulse is issued only if the second attempt also fails;
  - a resend-request byte 0xFE is not interpreted (treated as normal ACK timing).
- Undefined: single attempt; errors are reported immediately.

Test Plan:
- Bench setup: INHIBIT_CYCLES=10, START_TIMEOUT=200, XFER_TIMEOUT=2000. Keyboard model clocks at a 40-cycle period.
- Send 0xED, model ACKs -> clk_oe high exactly 10 cycles; model samples on rising edges bits 1,0,1,1,0,1,1,1, parity 1, stop 1; command_was_sent pulses once; busy falls in the same cycle.
- Send 0x01 -> parity sampled 0; send 0x00 -> parity 1; both ACKed.
- Model never clocks -> error_timeout pulses after 200 cycles in WAIT_FIRST; both oe=0 afterwards; busy=0.
- Model holds DAT high at the ACK clock -> error_nack pulse; command_was_sent stays 0.
- send_command re-strobed while busy with 0x55 -> ignored; original byte 0xFF transmitted unchanged.
- Assert reset during bit 4 -> oe's 0 and busy 0 immediately (async); no result pulse.
- With PS2_TX_RETRY_EN: first attempt NACKed, second ACKed -> only command_was_sent pulses; INHIBIT is observed twice.
